// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction in flight, round-robin on contention,
// read preferred when a granted master presents both AR and AW.

module axi_lite_arbiter_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel_rd,
    input  logic                  sel_wr,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_awready,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [1:0]            s_bresp,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  awready,
    output logic                  wready,
    output logic                  bvalid,
    output logic [1:0]            bresp
);
    // A master that does not own the active phase sees a silent, all-zero slave.
    assign arready = sel_rd & s_arready;
    assign rvalid  = sel_rd & s_rvalid;
    assign rdata   = sel_rd ? s_rdata : '0;
    assign rresp   = sel_rd ? s_rresp : 2'b00;
    assign awready = sel_wr & s_awready;
    assign wready  = sel_wr & s_wready;
    assign bvalid  = sel_wr & s_bvalid;
    assign bresp   = sel_wr ? s_bresp : 2'b00;
endmodule

module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // master 0
    input  logic [ADDR_WIDTH-1:0]   M0_ARADDR,
    input  logic                    M0_ARVALID,
    output logic                    M0_ARREADY,
    output logic [DATA_WIDTH-1:0]   M0_RDATA,
    output logic [1:0]              M0_RRESP,
    output logic                    M0_RVALID,
    input  logic                    M0_RREADY,
    input  logic [ADDR_WIDTH-1:0]   M0_AWADDR,
    input  logic                    M0_AWVALID,
    output logic                    M0_AWREADY,
    input  logic [DATA_WIDTH-1:0]   M0_WDATA,
    input  logic [DATA_WIDTH/8-1:0] M0_WSTRB,
    input  logic                    M0_WVALID,
    output logic                    M0_WREADY,
    output logic [1:0]              M0_BRESP,
    output logic                    M0_BVALID,
    input  logic                    M0_BREADY,
    // master 1
    input  logic [ADDR_WIDTH-1:0]   M1_ARADDR,
    input  logic                    M1_ARVALID,
    output logic                    M1_ARREADY,
    output logic [DATA_WIDTH-1:0]   M1_RDATA,
    output logic [1:0]              M1_RRESP,
    output logic                    M1_RVALID,
    input  logic                    M1_RREADY,
    input  logic [ADDR_WIDTH-1:0]   M1_AWADDR,
    input  logic                    M1_AWVALID,
    output logic                    M1_AWREADY,
    input  logic [DATA_WIDTH-1:0]   M1_WDATA,
    input  logic [DATA_WIDTH/8-1:0] M1_WSTRB,
    input  logic                    M1_WVALID,
    output logic                    M1_WREADY,
    output logic [1:0]              M1_BRESP,
    output logic                    M1_BVALID,
    input  logic                    M1_BREADY,
    // shared slave
    output logic [ADDR_WIDTH-1:0]   S_ARADDR,
    output logic                    S_ARVALID,
    input  logic                    S_ARREADY,
    input  logic [DATA_WIDTH-1:0]   S_RDATA,
    input  logic [1:0]              S_RRESP,
    input  logic                    S_RVALID,
    output logic                    S_RREADY,
    output logic [ADDR_WIDTH-1:0]   S_AWADDR,
    output logic                    S_AWVALID,
    input  logic                    S_AWREADY,
    output logic [DATA_WIDTH-1:0]   S_WDATA,
    output logic [DATA_WIDTH/8-1:0] S_WSTRB,
    output logic                    S_WVALID,
    input  logic                    S_WREADY,
    input  logic [1:0]              S_BRESP,
    input  logic                    S_BVALID,
    output logic                    S_BREADY,
    output logic [1:0]              GRANT
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    logic [1:0][ADDR_WIDTH-1:0] araddr, awaddr;
    logic [1:0][DATA_WIDTH-1:0] wdata, rdata;
    logic [1:0][STRB_W-1:0]     wstrb;
    logic [1:0][1:0]            rresp, bresp;
    logic [1:0]                 arvalid, awvalid, wvalid, rready, bready;
    logic [1:0]                 arready, rvalid, awready, wready, bvalid;

    assign araddr  = {M1_ARADDR,  M0_ARADDR};
    assign awaddr  = {M1_AWADDR,  M0_AWADDR};
    assign wdata   = {M1_WDATA,   M0_WDATA};
    assign wstrb   = {M1_WSTRB,   M0_WSTRB};
    assign arvalid = {M1_ARVALID, M0_ARVALID};
    assign awvalid = {M1_AWVALID, M0_AWVALID};
    assign wvalid  = {M1_WVALID,  M0_WVALID};
    assign rready  = {M1_RREADY,  M0_RREADY};
    assign bready  = {M1_BREADY,  M0_BREADY};

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic [1:0] grant_q;
    logic [1:0] req;
    logic       winner;
    logic       in_rd, in_wr;
    logic       rd_done, wr_done;

    assign req   = arvalid | awvalid;
    // On contention the master that did not finish last wins; otherwise the sole requester.
    assign winner  = (&req) ? ~last_owner : req[1];
    assign in_rd   = (state == RD);
    assign in_wr   = (state == WR);
    assign rd_done = in_rd & S_RVALID & rready[owner];
    assign wr_done = in_wr & S_BVALID & bready[owner];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            grant_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    owner   <= winner;
                    grant_q <= winner ? 2'b10 : 2'b01;
                    state   <= arvalid[winner] ? RD : WR;
                end
                RD: if (rd_done) begin
                    state      <= IDLE;
                    last_owner <= owner;
                    grant_q    <= 2'b00;
                end
                WR: if (wr_done) begin
                    state      <= IDLE;
                    last_owner <= owner;
                    grant_q    <= 2'b00;
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign GRANT = grant_q;

    assign S_ARADDR  = in_rd ? araddr[owner] : '0;
    assign S_ARVALID = in_rd & arvalid[owner];
    assign S_RREADY  = in_rd & rready[owner];
    assign S_AWADDR  = in_wr ? awaddr[owner] : '0;
    assign S_AWVALID = in_wr & awvalid[owner];
    assign S_WDATA   = in_wr ? wdata[owner] : '0;
    assign S_WSTRB   = in_wr ? wstrb[owner] : '0;
    assign S_WVALID  = in_wr & wvalid[owner];
    assign S_BREADY  = in_wr & bready[owner];

    for (genvar g = 0; g < 2; g++) begin : g_port
        axi_lite_arbiter_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
            .sel_rd    (in_rd & (owner == 1'(g))),
            .sel_wr    (in_wr & (owner == 1'(g))),
            .s_arready (S_ARREADY),
            .s_rvalid  (S_RVALID),
            .s_rdata   (S_RDATA),
            .s_rresp   (S_RRESP),
            .s_awready (S_AWREADY),
            .s_wready  (S_WREADY),
            .s_bvalid  (S_BVALID),
            .s_bresp   (S_BRESP),
            .arready   (arready[g]),
            .rvalid    (rvalid[g]),
            .rdata     (rdata[g]),
            .rresp     (rresp[g]),
            .awready   (awready[g]),
            .wready    (wready[g]),
            .bvalid    (bvalid[g]),
            .bresp     (bresp[g])
        );
    end

    assign M0_ARREADY = arready[0];
    assign M0_RVALID  = rvalid[0];
    assign M0_RDATA   = rdata[0];
    assign M0_RRESP   = rresp[0];
    assign M0_AWREADY = awready[0];
    assign M0_WREADY  = wready[0];
    assign M0_BVALID  = bvalid[0];
    assign M0_BRESP   = bresp[0];
    assign M1_ARREADY = arready[1];
    assign M1_RVALID  = rvalid[1];
    assign M1_RDATA   = rdata[1];
    assign M1_RRESP   = rresp[1];
    assign M1_AWREADY = awready[1];
    assign M1_WREADY  = wready[1];
    assign M1_BVALID  = bvalid[1];
    assign M1_BRESP   = bresp[1];
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Random per-cycle stimulus on both masters and the slave, compared against a transaction-level
// ownership model (who holds the slave, for what kind of access, who finished last).

module tb_axi_lite_arbiter;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    logic [1:0][31:0] araddr, awaddr, wdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0]       arv, awv, wv, rrdy, brdy;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;

    logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
    logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
    logic [31:0] s_araddr_o, s_awaddr_o, s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_arvalid_o, s_rready_o, s_awvalid_o, s_wvalid_o, s_bready_o;
    logic [1:0]  grant;

    axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M0_ARADDR(araddr[0]), .M0_ARVALID(arv[0]), .M0_ARREADY(m0_arready),
        .M0_RDATA(m0_rdata), .M0_RRESP(m0_rresp), .M0_RVALID(m0_rvalid), .M0_RREADY(rrdy[0]),
        .M0_AWADDR(awaddr[0]), .M0_AWVALID(awv[0]), .M0_AWREADY(m0_awready),
        .M0_WDATA(wdata[0]), .M0_WSTRB(wstrb[0]), .M0_WVALID(wv[0]), .M0_WREADY(m0_wready),
        .M0_BRESP(m0_bresp), .M0_BVALID(m0_bvalid), .M0_BREADY(brdy[0]),
        .M1_ARADDR(araddr[1]), .M1_ARVALID(arv[1]), .M1_ARREADY(m1_arready),
        .M1_RDATA(m1_rdata), .M1_RRESP(m1_rresp), .M1_RVALID(m1_rvalid), .M1_RREADY(rrdy[1]),
        .M1_AWADDR(awaddr[1]), .M1_AWVALID(awv[1]), .M1_AWREADY(m1_awready),
        .M1_WDATA(wdata[1]), .M1_WSTRB(wstrb[1]), .M1_WVALID(wv[1]), .M1_WREADY(m1_wready),
        .M1_BRESP(m1_bresp), .M1_BVALID(m1_bvalid), .M1_BREADY(brdy[1]),
        .S_ARADDR(s_araddr_o), .S_ARVALID(s_arvalid_o), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready_o),
        .S_AWADDR(s_awaddr_o), .S_AWVALID(s_awvalid_o), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata_o), .S_WSTRB(s_wstrb_o), .S_WVALID(s_wvalid_o), .S_WREADY(s_wready),
        .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready_o),
        .GRANT(grant)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: cur = master holding the slave (-1 when free), is_wr = kind of access, last = last finisher.
    int cur  = -1;
    bit is_wr = 1'b0;
    int last = 1;

    task automatic model_step();
        bit r0, r1;
        int w;
        if (cur < 0) begin
            r0 = arv[0] | awv[0];
            r1 = arv[1] | awv[1];
            w  = -1;
            if (r0 && r1) w = 1 - last;
            else if (r0)  w = 0;
            else if (r1)  w = 1;
            if (w >= 0) begin
                cur   = w;
                is_wr = !arv[w];
            end
        end else if (!is_wr) begin
            if (s_rvalid && rrdy[cur]) begin last = cur; cur = -1; end
        end else begin
            if (s_bvalid && brdy[cur]) begin last = cur; cur = -1; end
        end
    endtask

    task automatic check_outputs();
        bit rd, wr, own_rd, own_wr;
        int o;
        logic [127:0] got, exp;
        rd = (cur >= 0) && !is_wr;
        wr = (cur >= 0) && is_wr;
        o  = (cur < 0) ? 0 : cur;
        check("grant", grant, (cur < 0) ? 2'b00 : (2'b01 << cur));
        check("s_ctl", {s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o},
              {rd & arv[o], wr & awv[o], wr & wv[o], rd & rrdy[o], wr & brdy[o]});
        if (rd) check("s_araddr", s_araddr_o, araddr[o]);
        if (wr) check("s_wpath", {s_awaddr_o, s_wdata_o, s_wstrb_o}, {awaddr[o], wdata[o], wstrb[o]});
        for (int m = 0; m < 2; m++) begin
            own_rd = rd && (cur == m);
            own_wr = wr && (cur == m);
            exp = {own_rd & s_arready, own_rd & s_rvalid, own_rd ? s_rresp : 2'b00,
                   own_rd ? s_rdata : 32'h0, own_wr & s_awready, own_wr & s_wready,
                   own_wr & s_bvalid, own_wr ? s_bresp : 2'b00};
            if (m == 0)
                got = {m0_arready, m0_rvalid, m0_rresp, m0_rdata, m0_awready, m0_wready, m0_bvalid, m0_bresp};
            else
                got = {m1_arready, m1_rvalid, m1_rresp, m1_rdata, m1_awready, m1_wready, m1_bvalid, m1_bresp};
            check(m == 0 ? "m0_resp" : "m1_resp", got, exp);
        end
    endtask

    task automatic randomize_inputs();
        for (int m = 0; m < 2; m++) begin
            arv[m]    = ($urandom_range(0, 99) < 35);
            awv[m]    = ($urandom_range(0, 99) < 35);
            wv[m]     = 1'($urandom);
            rrdy[m]   = ($urandom_range(0, 99) < 55);
            brdy[m]   = ($urandom_range(0, 99) < 55);
            araddr[m] = $urandom;
            awaddr[m] = $urandom;
            wdata[m]  = $urandom;
            wstrb[m]  = 4'($urandom);
        end
        s_arready = 1'($urandom);
        s_awready = 1'($urandom);
        s_wready  = 1'($urandom);
        s_rvalid  = ($urandom_range(0, 99) < 45);
        s_bvalid  = ($urandom_range(0, 99) < 45);
        s_rdata   = $urandom;
        s_rresp   = 2'($urandom);
        s_bresp   = 2'($urandom);
    endtask

    initial begin
        randomize_inputs();
        for (int i = 0; i < 4000; i++) begin
            @(negedge ACLK);
            randomize_inputs();
            if (i < 3)       ARESET = 1'b1;
            else if (ARESET) ARESET = 1'($urandom);
            else             ARESET = ($urandom_range(0, 99) < 2);
            // Asynchronous reset: ownership is lost the moment it rises.
            if (ARESET) begin
                cur  = -1;
                last = 1;
            end
            #1;
            check_outputs();
            @(posedge ACLK);
            if (!ARESET) model_step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
